buffer_ctrl: RTL and testbench

//  Owning controller for the fully-associative row buffer. Upstream write requests arrive on a valid/ready port.
//  The block allocates buffer cells in ring order, drives the buffer's wr_* and rls_* ports, and captures the

---
 rtl/buffer_ctrl.sv | 157 +++++++++++++++
 tb/tb_buffer_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_ctrl.sv
// Owning controller for the fully-associative row buffer: ring allocation, oldest-first eviction,
// and a 2-entry writeback queue toward memory. Optional idle drain: BUF_CTRL_IDLE_DRAIN_EN.
module buffer_ctrl #(
   parameter int WIDTH_ADDR = 8,
   parameter int WIDTH_ROW  = 512,
   parameter int DEPTH      = 8,
   parameter int DEPTH_PTR  = 3,
   parameter int IDLE_LIMIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_val,
   output logic                  req_rdy,
   input  logic [WIDTH_ADDR-1:0] req_addr,
   input  logic [WIDTH_ROW-1:0]  req_data,
   input  logic                  flush,
   output logic                  flush_done,
   output logic                  buf_wr_val,
   output logic [WIDTH_ADDR-1:0] buf_wr_addr,
   output logic [WIDTH_ROW-1:0]  buf_wr_data,
   output logic [DEPTH_PTR-1:0]  buf_wr_cell,
   output logic                  buf_rls_val,
   output logic [DEPTH_PTR-1:0]  buf_rls_cell,
   input  logic                  buf_wrb_val,
   input  logic [WIDTH_ADDR-1:0] buf_wrb_addr,
   input  logic [WIDTH_ROW-1:0]  buf_wrb_data,
   output logic                  mem_val,
   input  logic                  mem_rdy,
   output logic [WIDTH_ADDR-1:0] mem_addr,
   output logic [WIDTH_ROW-1:0]  mem_data,
   output logic [DEPTH_PTR:0]    occupancy
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;
   localparam logic [DEPTH_PTR:0] OCC_FULL = (DEPTH_PTR + 1)'(DEPTH);

   logic [0:0]            state_reg, state_next;
   logic [DEPTH_PTR-1:0]  alloc_ptr_reg;
   logic [DEPTH_PTR-1:0]  rls_ptr_reg;
   logic [DEPTH_PTR:0]    occ_reg, occ_next;
   logic                  inflight_reg;
   logic [1:0]            q_count_reg, q_count_next;
   logic                  q_wr_idx_reg;
   logic                  q_rd_idx_reg;
   logic [WIDTH_ADDR-1:0] q_addr_reg [2];
   logic [WIDTH_ROW-1:0]  q_data_reg [2];

   logic acc;
   logic ev;
   logic credit;
   logic idle_fire;
   logic q_pop;
   logic full;
   logic nonempty;
   logic drained;

   assign full     = (occ_reg == OCC_FULL);
   assign nonempty = (occ_reg != '0);

   // Ready depends on registers only, so the upstream handshake has no combinational loop.
   assign req_rdy = (state_reg == ST_RUN) & ~full;
   assign acc     = req_val & req_rdy;

   // A release now produces a writeback next cycle; reserve its queue slot up front.
   assign credit = (({1'b0, q_count_reg} + {2'b00, inflight_reg}) < 3'd2);
   assign ev     = credit & nonempty &
                   ((state_reg == ST_FLUSH) | (full & req_val) | idle_fire);

   assign mem_val = (q_count_reg != 2'd0);
   assign q_pop   = mem_val & mem_rdy;
   assign drained = ~nonempty & ~inflight_reg & (q_count_reg == 2'd0);

   assign flush_done = (state_reg == ST_FLUSH) & drained;

   assign buf_wr_val   = acc;
   assign buf_wr_addr  = acc ? req_addr : '0;
   assign buf_wr_data  = acc ? req_data : '0;
   assign buf_wr_cell  = alloc_ptr_reg;
   assign buf_rls_val  = ev;
   assign buf_rls_cell = rls_ptr_reg;

   assign mem_addr  = mem_val ? q_addr_reg[q_rd_idx_reg] : '0;
   assign mem_data  = mem_val ? q_data_reg[q_rd_idx_reg] : '0;
   assign occupancy = occ_reg;

   always_comb begin
      state_next = state_reg;
      if (state_reg == ST_RUN) begin
         if (flush) state_next = ST_FLUSH;
      end else begin
         if (drained) state_next = ST_RUN;
      end
   end

   always_comb begin
      occ_next     = occ_reg + {{DEPTH_PTR{1'b0}}, acc} - {{DEPTH_PTR{1'b0}}, ev};
      q_count_next = q_count_reg + {1'b0, buf_wrb_val} - {1'b0, q_pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_RUN;
         alloc_ptr_reg <= '0;
         rls_ptr_reg   <= '0;
         occ_reg       <= '0;
         inflight_reg  <= 1'b0;
         q_count_reg   <= 2'd0;
         q_wr_idx_reg  <= 1'b0;
         q_rd_idx_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         occ_reg      <= occ_next;
         inflight_reg <= ev;
         q_count_reg  <= q_count_next;
         if (acc)         alloc_ptr_reg <= alloc_ptr_reg + DEPTH_PTR'(1);
         if (ev)          rls_ptr_reg   <= rls_ptr_reg + DEPTH_PTR'(1);
         if (buf_wrb_val) q_wr_idx_reg  <= ~q_wr_idx_reg;
         if (q_pop)       q_rd_idx_reg  <= ~q_rd_idx_reg;
      end
   end

   // Queue payload carries no reset; outputs are masked by mem_val instead.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_queue
         always_ff @(posedge clk) begin
            if (buf_wrb_val && (q_wr_idx_reg == 1'(gi))) begin
               q_addr_reg[gi] <= buf_wrb_addr;
               q_data_reg[gi] <= buf_wrb_data;
            end
         end
      end
   endgenerate

`ifdef BUF_CTRL_IDLE_DRAIN_EN
   localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_LIMIT);

   logic [IDLE_W-1:0] idle_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || acc) begin
         idle_cnt_reg <= '0;
      end else if (idle_cnt_reg != IDLE_MAX) begin
         idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
      end
   end

   assign idle_fire = (idle_cnt_reg == IDLE_MAX) & nonempty;
`else
   logic unused_idle_limit;
   assign unused_idle_limit = (IDLE_LIMIT != 0);
   assign idle_fire = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl with a behavioural row buffer answering rls with wrb one cycle later.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_buffer_ctrl;

   localparam int WA = 8;
   localparam int WR = 512;
   localparam int DP = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_val;
   logic          req_rdy;
   logic [WA-1:0] req_addr;
   logic [WR-1:0] req_data;
   logic          flush;
   logic          flush_done;
   logic          buf_wr_val;
   logic [WA-1:0] buf_wr_addr;
   logic [WR-1:0] buf_wr_data;
   logic [DP-1:0] buf_wr_cell;
   logic          buf_rls_val;
   logic [DP-1:0] buf_rls_cell;
   logic          buf_wrb_val;
   logic [WA-1:0] buf_wrb_addr;
   logic [WR-1:0] buf_wrb_data;
   logic          mem_val;
   logic          mem_rdy;
   logic [WA-1:0] mem_addr;
   logic [WR-1:0] mem_data;
   logic [DP:0]   occupancy;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   logic [WA-1:0] got_addr [$];
   logic [WR-1:0] got_data [$];
   logic [DP-1:0] rls_log  [$];

   always #5 clk = ~clk;

   buffer_ctrl #(
      .WIDTH_ADDR(WA), .WIDTH_ROW(WR), .DEPTH(8), .DEPTH_PTR(DP), .IDLE_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_data(req_data),
      .flush(flush), .flush_done(flush_done),
      .buf_wr_val(buf_wr_val), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .buf_wr_cell(buf_wr_cell),
      .buf_rls_val(buf_rls_val), .buf_rls_cell(buf_rls_cell),
      .buf_wrb_val(buf_wrb_val), .buf_wrb_addr(buf_wrb_addr), .buf_wrb_data(buf_wrb_data),
      .mem_val(mem_val), .mem_rdy(mem_rdy), .mem_addr(mem_addr), .mem_data(mem_data),
      .occupancy(occupancy)
   );

   // Row buffer model: stores written rows, returns the released row one cycle later.
   logic [WA-1:0] cell_addr [8];
   logic [WR-1:0] cell_data [8];

   always @(posedge clk) begin
      if (rst) begin
         buf_wrb_val  <= 1'b0;
         buf_wrb_addr <= '0;
         buf_wrb_data <= '0;
      end else begin
         if (buf_wr_val) begin
            cell_addr[buf_wr_cell] <= buf_wr_addr;
            cell_data[buf_wr_cell] <= buf_wr_data;
         end
         buf_wrb_val  <= buf_rls_val;
         buf_wrb_addr <= cell_addr[buf_rls_cell];
         buf_wrb_data <= cell_data[buf_rls_cell];
      end
   end

   function automatic logic [WR-1:0] pat(input logic [WA-1:0] a);
      return {{63{a}}, ~a};
   endfunction

   // Called at a falling edge: logs what completes at the coming rising edge, then advances.
   task automatic adv();
      if (mem_val && mem_rdy) begin
         got_addr.push_back(mem_addr);
         got_data.push_back(mem_data);
         $display("mem write addr=%02h", mem_addr);
      end
      if (buf_rls_val) rls_log.push_back(buf_rls_cell);
      if (flush_done) done_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc();
      @(negedge clk);
      adv();
   endtask

   task automatic do_reset();
      rst = 1'b1; req_val = 1'b0; req_addr = '0; req_data = '0; flush = 1'b0; mem_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_addr.delete(); got_data.delete(); rls_log.delete(); done_cnt = 0;
   endtask

   task automatic fill8();
      for (int i = 0; i < 8; i++) begin
         req_val = 1'b1; req_addr = WA'(8'h10 + i); req_data = pat(req_addr);
         @(negedge clk);
         adv();
      end
      req_val = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_req_rdy: got %0b expected 1", req_rdy); end
      n_cmp++; if (mem_val !== 1'b0) begin n_bad++; $display("FAIL reset_mem_val: got %0b expected 0", mem_val); end
      n_cmp++; if (buf_rls_val !== 1'b0) begin n_bad++; $display("FAIL reset_rls_val: got %0b expected 0", buf_rls_val); end
      n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done: got %0b expected 0", flush_done); end
      n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
      n_cmp++; if (buf_wr_cell !== 3'd0) begin n_bad++; $display("FAIL reset_wr_cell: got %0d expected 0", buf_wr_cell); end
      adv();
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req_val = 1'b1; req_addr = WA'(8'h10 + i); req_data = pat(req_addr);
         @(negedge clk);
         n_cmp++; if (buf_wr_val !== 1'b1) begin n_bad++; $display("FAIL fill_wr_val[%0d]: got %0b expected 1", i, buf_wr_val); end
         n_cmp++; if (buf_wr_cell !== DP'(i)) begin n_bad++; $display("FAIL fill_wr_cell[%0d]: got %0d expected %0d", i, buf_wr_cell, i); end
         adv();
      end
      req_val = 1'b0;
      @(negedge clk);
      n_cmp++; if (occupancy !== 4'd8) begin n_bad++; $display("FAIL fill_occupancy: got %0d expected 8", occupancy); end
      n_cmp++; if (req_rdy !== 1'b0) begin n_bad++; $display("FAIL fill_req_rdy: got %0b expected 0", req_rdy); end
      n_cmp++; if (rls_log.size() != 0) begin n_bad++; $display("FAIL fill_no_rls: got %0d releases expected 0", rls_log.size()); end
      n_cmp++; if (buf_rls_val !== 1'b0) begin n_bad++; $display("FAIL fill_rls_val: got %0b expected 0", buf_rls_val); end
      adv();
   endtask

   // Continues from the full buffer left by test_fill.
   task automatic test_overflow();
      req_val = 1'b1; req_addr = 8'h20; req_data = pat(8'h20); mem_rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (buf_rls_val !== 1'b1) begin n_bad++; $display("FAIL ovf_rls_val: got %0b expected 1", buf_rls_val); end
      n_cmp++; if (buf_rls_cell !== 3'd0) begin n_bad++; $display("FAIL ovf_rls_cell: got %0d expected 0", buf_rls_cell); end
      n_cmp++; if (buf_wr_val !== 1'b0) begin n_bad++; $display("FAIL ovf_wr_blocked: got %0b expected 0", buf_wr_val); end
      adv();
      @(negedge clk);
      n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL ovf_req_rdy_t1: got %0b expected 1", req_rdy); end
      n_cmp++; if (buf_wr_val !== 1'b1) begin n_bad++; $display("FAIL ovf_wr_val_t1: got %0b expected 1", buf_wr_val); end
      n_cmp++; if (buf_wr_cell !== 3'd0) begin n_bad++; $display("FAIL ovf_wr_cell_t1: got %0d expected 0", buf_wr_cell); end
      n_cmp++; if (buf_rls_val !== 1'b0) begin n_bad++; $display("FAIL ovf_rls_t1: got %0b expected 0", buf_rls_val); end
      adv();
      req_val = 1'b0;
      @(negedge clk);
      n_cmp++; if (mem_val !== 1'b1) begin n_bad++; $display("FAIL ovf_mem_val: got %0b expected 1", mem_val); end
      n_cmp++; if (mem_addr !== 8'h10) begin n_bad++; $display("FAIL ovf_mem_addr: got %0h expected 10", mem_addr); end
      n_cmp++; if (mem_data !== pat(8'h10)) begin n_bad++; $display("FAIL ovf_mem_data: got %0h expected %0h", mem_data[15:0], pat(8'h10) & 512'hFFFF); end
      n_cmp++; if (occupancy !== 4'd8) begin n_bad++; $display("FAIL ovf_occupancy: got %0d expected 8", occupancy); end
      adv();
   endtask

   task automatic test_flush_stall();
      do_reset();
      fill8();
      mem_rdy = 1'b0; flush = 1'b1;
      idle_cyc();
      flush = 1'b0;
      repeat (6) idle_cyc();
      @(negedge clk);
      n_cmp++; if (rls_log.size() != 2) begin n_bad++; $display("FAIL stall_rls_count: got %0d expected 2", rls_log.size()); end
      n_cmp++; if (occupancy !== 4'd6) begin n_bad++; $display("FAIL stall_occupancy: got %0d expected 6", occupancy); end
      n_cmp++; if (mem_addr !== 8'h10) begin n_bad++; $display("FAIL stall_mem_addr: got %0h expected 10", mem_addr); end
      n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL stall_no_done: got %0d expected 0", done_cnt); end
      adv();
      mem_rdy = 1'b1;
      repeat (40) idle_cyc();
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL stall_done_pulses: got %0d expected 1", done_cnt); end
      n_cmp++; if (got_addr.size() != 8) begin n_bad++; $display("FAIL stall_rows: got %0d expected 8", got_addr.size()); end
      for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
         n_cmp++; if (got_addr[i] !== WA'(8'h10 + i)) begin n_bad++; $display("FAIL stall_order[%0d]: got %0h expected %0h", i, got_addr[i], 8'h10 + i); end
      end
      @(negedge clk);
      n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL stall_req_rdy: got %0b expected 1", req_rdy); end
      n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL stall_empty: got %0d expected 0", occupancy); end
      adv();
   endtask

   task automatic test_toggle();
      logic          hold;
      logic [WA-1:0] held_addr;
      logic [WR-1:0] held_data;
      int            n_hold;
      hold = 1'b0; held_addr = '0; held_data = '0; n_hold = 0;
      do_reset();
      fill8();
      for (int i = 0; i < 80; i++) begin
         mem_rdy = ((i % 2) == 1);
         flush = (i == 0);
         @(negedge clk);
         if (hold) begin
            n_hold++;
            n_cmp++; if (mem_addr !== held_addr || mem_data !== held_data) begin n_bad++; $display("FAIL toggle_hold[%0d]: got %0h expected %0h", i, mem_addr, held_addr); end
         end
         hold = mem_val && !mem_rdy;
         held_addr = mem_addr;
         held_data = mem_data;
         adv();
      end
      flush = 1'b0;
      n_cmp++; if (n_hold < 4) begin n_bad++; $display("FAIL toggle_hold_seen: got %0d expected at least 4", n_hold); end
      n_cmp++; if (got_addr.size() != 8) begin n_bad++; $display("FAIL toggle_rows: got %0d expected 8", got_addr.size()); end
      for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
         n_cmp++; if (got_addr[i] !== WA'(8'h10 + i) || got_data[i] !== pat(WA'(8'h10 + i))) begin n_bad++; $display("FAIL toggle_row[%0d]: got %0h expected %0h", i, got_addr[i], 8'h10 + i); end
      end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL toggle_done_pulses: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_empty_flush();
      do_reset();
      flush = 1'b1;
      @(negedge clk);
      n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL eflush_t0: got %0b expected 0", flush_done); end
      adv();
      flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (flush_done !== 1'b1) begin n_bad++; $display("FAIL eflush_t1: got %0b expected 1", flush_done); end
      adv();
      @(negedge clk);
      n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL eflush_t2: got %0b expected 0", flush_done); end
      n_cmp++; if (rls_log.size() != 0) begin n_bad++; $display("FAIL eflush_no_rls: got %0d expected 0", rls_log.size()); end
      adv();
   endtask

   task automatic test_rst_mid();
      do_reset();
      fill8();
      mem_rdy = 1'b0; flush = 1'b1;
      idle_cyc();
      flush = 1'b0;
      repeat (3) idle_cyc();
      @(negedge clk);
      n_cmp++; if (mem_val !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_val: got %0b expected 1", mem_val); end
      rst = 1'b1;
      adv();
      rst = 1'b0;
      got_addr.delete(); got_data.delete();
      @(negedge clk);
      n_cmp++; if (mem_val !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem_val: got %0b expected 0", mem_val); end
      n_cmp++; if (mem_addr !== 8'h00) begin n_bad++; $display("FAIL rstmid_mem_addr: got %0h expected 0", mem_addr); end
      n_cmp++; if (buf_rls_val !== 1'b0) begin n_bad++; $display("FAIL rstmid_rls_val: got %0b expected 0", buf_rls_val); end
      n_cmp++; if (flush_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %0b expected 0", flush_done); end
      n_cmp++; if (occupancy !== 4'd0) begin n_bad++; $display("FAIL rstmid_occupancy: got %0d expected 0", occupancy); end
      n_cmp++; if (req_rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_rdy: got %0b expected 1", req_rdy); end
      adv();
      mem_rdy = 1'b1;
      repeat (6) idle_cyc();
      n_cmp++; if (got_addr.size() != 0) begin n_bad++; $display("FAIL rstmid_lost_queue: got %0d rows expected 0", got_addr.size()); end
   endtask

   task automatic test_idle();
      int first;
      first = -1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req_val = 1'b1; req_addr = WA'(8'h30 + i); req_data = pat(req_addr);
         @(negedge clk);
         adv();
      end
      req_val = 1'b0;
      // k counts cycles after the last accept
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (buf_rls_val && first < 0) first = k;
         adv();
      end
`ifdef BUF_CTRL_IDLE_DRAIN_EN
      n_cmp++; if (first != 5) begin n_bad++; $display("FAIL idle_first_rls: got %0d expected 5", first); end
      n_cmp++; if (rls_log.size() != 3) begin n_bad++; $display("FAIL idle_rls_count: got %0d expected 3", rls_log.size()); end
      n_cmp++; if (got_addr.size() != 3) begin n_bad++; $display("FAIL idle_rows: got %0d expected 3", got_addr.size()); end
      for (int i = 0; i < 3 && i < got_addr.size(); i++) begin
         n_cmp++; if (got_addr[i] !== WA'(8'h30 + i)) begin n_bad++; $display("FAIL idle_order[%0d]: got %0h expected %0h", i, got_addr[i], 8'h30 + i); end
      end
`else
      n_cmp++; if (first != -1) begin n_bad++; $display("FAIL idle_no_rls: got first at %0d expected none", first); end
      @(negedge clk);
      n_cmp++; if (occupancy !== 4'd3) begin n_bad++; $display("FAIL idle_occupancy: got %0d expected 3", occupancy); end
      n_cmp++; if (mem_val !== 1'b0) begin n_bad++; $display("FAIL idle_mem_val: got %0b expected 0", mem_val); end
      adv();
`endif
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_flush_stall();
      test_toggle();
      test_empty_flush();
      test_rst_mid();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
